mux_arbitro_param: RTL and testbench
====================================

Name: mux_arbitro_param

Overview:
Parametrised, registered N-input selector with per-channel request/accept handshake and a valid/ready output stage. It generalises the processor's fixed 5-bit, 8-input key-selected mux. Channel selection uses one of three modes: fixed priority, round-robin or external key. It sits in front of shared resources (memory port, write-back bus) where several datapath sources compete for one destination.

Parameters:
LARGURA, 5, data width per channel in bits
N_ENTRADAS, 8, number of input channels (2..32; need not be a power of 2)
MODO, 1, selection mode: 0 fixed priority (lowest index wins), 1 round-robin, 2 external key
SEL_W, derived localparam = clog2(N_ENTRADAS) (minimum 1), width of index signals

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
entradas  in  N_ENTRADAS*LARGURA  channel i data at bits [i*LARGURA +: LARGURA]
req  in  N_ENTRADAS  per-channel request; requester holds req[i] and its data until aceito[i]
key  in  SEL_W  channel index used only in MODO 2
aceito  out  N_ENTRADAS  one-hot (or zero) accept, combinational; data of channel i captured at the edge where aceito[i]=1
saida  out  LARGURA  registered selected data
canal  out  SEL_W  registered index of the channel that produced saida
saida_valida  out  1  saida/canal hold a valid word
saida_pronta  in  1  consumer accepts saida at the edge where saida_valida && saida_pronta

Behaviour:
- Reset: saida=0, canal=0, saida_valida=0, round-robin pointer ptr=0. aceito is forced to 0 while reset=1. A word pending at reset is dropped.
- Output stage states:
  - VAZIO: saida_valida=0.
  - CHEIO: saida_valida=1.
- Load condition: carga = (!saida_valida || saida_pronta) && any eligible request.
- On carga, at the edge:
  - saida <= entradas[g]; canal <= g; saida_valida <= 1.
  - aceito[g]=1 during the preceding cycle, combinationally.
- Drain without load (saida_valida && saida_pronta && !carga): saida_valida <= 0. saida and canal keep their last value.
- Simultaneous drain and load is allowed, giving full throughput: one word per cycle while saida_pronta=1.
- Stall (saida_valida && !saida_pronta):
  - aceito = 0.
  - saida and canal are held bit-stable.
  - ptr is unchanged.
- Latency: a request granted in cycle t appears on saida with saida_valida=1 in cycle t+1.
- Grant g by mode:
  - MODO 0: lowest index i with req[i]=1.
  - MODO 1: first i with req[i]=1, searching ptr, ptr+1, ..., wrapping N_ENTRADAS-1 -> 0. On carga, ptr <= g+1, wrapping to 0 when g = N_ENTRADAS-1. The wrap is explicit; no power-of-2 modulo.
  - MODO 2: g = key only if key < N_ENTRADAS and req[key]=1. Otherwise there is no grant.
- At most one aceito bit is set per cycle. aceito depends only on req, key, ptr, saida_valida and saida_pronta; there is no combinational path from entradas.
- No request: no carga, aceito=0, state unchanged apart from a possible drain.
- req dropped by a requester before it is accepted is legal; that channel is simply not considered.

Decomposition:
- Package mux_pkg:
  - constants MODO_FIXO=0, MODO_RR=1, MODO_CHAVE=2;
  - function clog2 for SEL_W.
- Sub-module arbitro_rr: combinational. Inputs req and ptr (or a fixed 0 base in MODO 0); outputs the one-hot grant and its index g. It is instantiated for MODO 0/1 only.
- The top level holds the output register, ptr, the MODO 2 key decode and the handshake logic.

Test Plan:
- Reset: assert reset 2 cycles with req=8'hFF, saida_pronta=1 -> aceito=0, saida_valida=0, saida=0, canal=0. After release, the first grant is channel 0 (MODO 1, ptr=0).
- Round-robin fairness (MODO 1, N=8, entrada i = i+10, req=8'hFF, saida_pronta=1) -> canal sequence 0,1,...,7,0 on consecutive cycles, saida 10..17, saida_valida continuously 1.
- Non-power-of-2 wrap (N=5, MODO 1, req=5'b10001) -> canal sequence 0,4,0,4. ptr wraps 4 -> 0; index 5..7 is never produced.
- Backpressure (MODO 0, req=8'b0000_0110, saida_pronta=0 for 3 cycles after the first load) -> canal=1 and saida held stable, aceito=0 during the stall. When saida_pronta rises, channel 1 is loaded again if still requesting; otherwise channel 2.
- Key mode (MODO 2, N=6, req=6'b001000): key=3 -> aceito=6'b001000, canal=3 next cycle. key=7 or key=2 -> aceito=0, saida_valida falls to 0 after a drain.
- Reset mid-operation: saida_valida=1 with saida_pronta=0, then reset for 1 cycle -> saida_valida=0, ptr=0. The held word is never delivered.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants, output-stage state type and width helper for the
// parametrised request/accept selector.
package mux_pkg;

    localparam int unsigned MODO_FIXO  = 0;
    localparam int unsigned MODO_RR    = 1;
    localparam int unsigned MODO_CHAVE = 2;

    typedef enum logic [0:0] {
        StVazio,
        StCheio
    } estado_t;

    // Index width for n channels; never below one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Combinational rotating-priority arbiter: searches i_ptr, i_ptr+1, ... with an
// explicit wrap, so non-power-of-2 channel counts never yield an index >= N_ENTRADAS.
module arbitro_rr
    import mux_pkg::*;
#(
    parameter int unsigned N_ENTRADAS = 8,
    parameter int unsigned SEL_W      = clog2(N_ENTRADAS)
) (
    input  logic [N_ENTRADAS-1:0] i_req,
    input  logic [SEL_W-1:0]      i_ptr,
    output logic [N_ENTRADAS-1:0] o_grant,
    output logic [SEL_W-1:0]      o_g,
    output logic                  o_valido
);

    int unsigned w_pos;

    always_comb begin
        o_grant  = '0;
        o_g      = '0;
        o_valido = 1'b0;
        w_pos    = 0;
        for (int unsigned k = 0; k < N_ENTRADAS; k++) begin
            w_pos = 32'(i_ptr) + k;
            if (w_pos >= N_ENTRADAS) begin
                w_pos = w_pos - N_ENTRADAS;
            end
            if (!o_valido && i_req[w_pos[SEL_W-1:0]]) begin
                o_valido                   = 1'b1;
                o_grant[w_pos[SEL_W-1:0]]  = 1'b1;
                o_g                        = w_pos[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_arbitro_param.sv
// Registered N-input selector: per-channel req/aceito handshake in front of a
// one-word valid/ready output stage, with fixed, round-robin or key selection.
module mux_arbitro_param
    import mux_pkg::*;
#(
    parameter  int unsigned LARGURA    = 5,
    parameter  int unsigned N_ENTRADAS = 8,
    parameter  int unsigned MODO       = 1,
    localparam int unsigned SEL_W      = clog2(N_ENTRADAS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_ENTRADAS*LARGURA-1:0] entradas,
    input  logic [N_ENTRADAS-1:0]         req,
    input  logic [SEL_W-1:0]              key,
    output logic [N_ENTRADAS-1:0]         aceito,
    output logic [LARGURA-1:0]            saida,
    output logic [SEL_W-1:0]              canal,
    output logic                          saida_valida,
    input  logic                          saida_pronta
);

    estado_t r_estado, w_estado_prox;

    logic [SEL_W-1:0]      r_ptr;
    logic [LARGURA-1:0]    r_saida;
    logic [SEL_W-1:0]      r_canal;

    logic [SEL_W-1:0]      w_ptr_base;
    logic [N_ENTRADAS-1:0] w_grant_arb, w_grant_key, w_grant;
    logic [SEL_W-1:0]      w_g_arb, w_g_key, w_g;
    logic                  w_ok_arb, w_ok_key, w_ok;
    logic                  w_livre, w_carga;
    logic [LARGURA-1:0]    w_dado;

    assign saida_valida = (r_estado == StCheio);
    assign saida        = r_saida;
    assign canal        = r_canal;

    // Stage can take a new word when empty or when the current one drains this edge.
    assign w_livre = !saida_valida || saida_pronta;

    // Key decode by comparison against each channel, so out-of-range keys never match.
    always_comb begin
        w_grant_key = '0;
        w_g_key     = '0;
        w_ok_key    = 1'b0;
        for (int unsigned i = 0; i < N_ENTRADAS; i++) begin
            if (32'(key) == i && req[i]) begin
                w_grant_key[i] = 1'b1;
                w_g_key        = key;
                w_ok_key       = 1'b1;
            end
        end
    end

    assign w_ptr_base = (MODO == MODO_RR) ? r_ptr : '0;

    if (MODO != MODO_CHAVE) begin : g_arbitro
        arbitro_rr #(
            .N_ENTRADAS (N_ENTRADAS),
            .SEL_W      (SEL_W)
        ) u_arbitro (
            .i_req    (req),
            .i_ptr    (w_ptr_base),
            .o_grant  (w_grant_arb),
            .o_g      (w_g_arb),
            .o_valido (w_ok_arb)
        );
    end else begin : g_sem_arbitro
        assign w_grant_arb = '0;
        assign w_g_arb     = '0;
        assign w_ok_arb    = 1'b0;
    end

    assign w_grant = (MODO == MODO_CHAVE) ? w_grant_key : w_grant_arb;
    assign w_g     = (MODO == MODO_CHAVE) ? w_g_key     : w_g_arb;
    assign w_ok    = (MODO == MODO_CHAVE) ? w_ok_key    : w_ok_arb;

    assign w_carga = !reset && w_livre && w_ok;
    assign aceito  = w_carga ? w_grant : '0;

    always_comb begin
        w_dado = '0;
        for (int unsigned i = 0; i < N_ENTRADAS; i++) begin
            if (32'(w_g) == i) begin
                w_dado = entradas[i*LARGURA +: LARGURA];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= StVazio;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    always_comb begin
        w_estado_prox = r_estado;
        unique case (r_estado)
            StVazio: begin
                if (w_carga) begin
                    w_estado_prox = StCheio;
                end
            end
            StCheio: begin
                if (saida_pronta && !w_carga) begin
                    w_estado_prox = StVazio;
                end
            end
            default: w_estado_prox = StVazio;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_saida <= '0;
            r_canal <= '0;
            r_ptr   <= '0;
        end else if (w_carga) begin
            r_saida <= w_dado;
            r_canal <= w_g;
            if (MODO == MODO_RR) begin
                r_ptr <= (32'(w_g) == N_ENTRADAS - 1) ? '0 : w_g + 1'b1;
            end
        end
    end

    a_aceito_onehot: assert property (@(posedge clock) $onehot0(aceito));

    a_stall_estavel: assert property (@(posedge clock) disable iff (reset)
        saida_valida && !saida_pronta |=> $stable(saida) && $stable(canal));

endmodule

// File: tb/tb_mux_arbitro_param.sv
// Drives four configurations side by side (RR N=8, RR N=5, fixed N=8, key N=6)
// and compares every cycle against a queue-free arithmetic reference model.
module tb_mux_arbitro_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] t_req   [4];
    logic [2:0] t_key   [4];
    logic       t_pronta[4];
    logic [4:0] t_ent   [4][8];
    logic [39:0] ent_flat[4];

    logic [7:0] acc0;
    logic [4:0] acc1;
    logic [7:0] acc2;
    logic [5:0] acc3;
    logic [7:0] d_aceito[4];
    logic [4:0] d_saida [4];
    logic [2:0] d_canal [4];
    logic       d_valid [4];

    int cfg_n[4] = '{8, 5, 8, 6};
    int cfg_m[4] = '{1, 1, 0, 2};

    bit m_valid[4];
    int m_saida[4];
    int m_canal[4];
    int m_ptr  [4];

    int n_checks = 0;
    int n_pass   = 0;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ent_flat[k] = '0;
            for (int i = 0; i < 8; i++) begin
                ent_flat[k][i*5 +: 5] = t_ent[k][i];
            end
        end
    end

    always_comb begin
        d_aceito[0] = acc0;
        d_aceito[1] = {3'b000, acc1};
        d_aceito[2] = acc2;
        d_aceito[3] = {2'b00, acc3};
    end

    mux_arbitro_param #(.LARGURA(5), .N_ENTRADAS(8), .MODO(1)) u_rr8 (
        .clock(clk), .reset(rst), .entradas(ent_flat[0]), .req(t_req[0]), .key(t_key[0]),
        .aceito(acc0), .saida(d_saida[0]), .canal(d_canal[0]), .saida_valida(d_valid[0]),
        .saida_pronta(t_pronta[0])
    );

    mux_arbitro_param #(.LARGURA(5), .N_ENTRADAS(5), .MODO(1)) u_rr5 (
        .clock(clk), .reset(rst), .entradas(ent_flat[1][24:0]), .req(t_req[1][4:0]),
        .key(t_key[1]), .aceito(acc1), .saida(d_saida[1]), .canal(d_canal[1]),
        .saida_valida(d_valid[1]), .saida_pronta(t_pronta[1])
    );

    mux_arbitro_param #(.LARGURA(5), .N_ENTRADAS(8), .MODO(0)) u_fix8 (
        .clock(clk), .reset(rst), .entradas(ent_flat[2]), .req(t_req[2]), .key(t_key[2]),
        .aceito(acc2), .saida(d_saida[2]), .canal(d_canal[2]), .saida_valida(d_valid[2]),
        .saida_pronta(t_pronta[2])
    );

    mux_arbitro_param #(.LARGURA(5), .N_ENTRADAS(6), .MODO(2)) u_key6 (
        .clock(clk), .reset(rst), .entradas(ent_flat[3][29:0]), .req(t_req[3][5:0]),
        .key(t_key[3]), .aceito(acc3), .saida(d_saida[3]), .canal(d_canal[3]),
        .saida_valida(d_valid[3]), .saida_pronta(t_pronta[3])
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Granted channel for instance k this cycle, or -1 when nothing is accepted.
    function automatic int ref_grant(int k);
        int n;
        n = cfg_n[k];
        if (m_valid[k] && !t_pronta[k]) return -1;
        case (cfg_m[k])
            0: begin
                for (int i = 0; i < n; i++) begin
                    if (t_req[k][i]) return i;
                end
            end
            1: begin
                for (int j = 0; j < n; j++) begin
                    int i;
                    i = (m_ptr[k] + j) % n;
                    if (t_req[k][i]) return i;
                end
            end
            default: begin
                if (int'(t_key[k]) < n && t_req[k][t_key[k]]) return int'(t_key[k]);
            end
        endcase
        return -1;
    endfunction

    task automatic step(input bit rst_v);
        int g[4];
        rst = rst_v;
        #1;
        for (int k = 0; k < 4; k++) begin
            g[k] = rst_v ? -1 : ref_grant(k);
            check_eq($sformatf("aceito[%0d]", k), int'(d_aceito[k]),
                     (g[k] < 0) ? 0 : (1 << g[k]));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (rst_v) begin
                m_valid[k] = 1'b0;
                m_saida[k] = 0;
                m_canal[k] = 0;
                m_ptr[k]   = 0;
            end else if (g[k] >= 0) begin
                m_saida[k] = int'(t_ent[k][g[k]]);
                m_canal[k] = g[k];
                m_valid[k] = 1'b1;
                if (cfg_m[k] == 1) m_ptr[k] = (g[k] + 1) % cfg_n[k];
            end else if (m_valid[k] && t_pronta[k]) begin
                m_valid[k] = 1'b0;
            end
            check_eq($sformatf("valida[%0d]", k), int'(d_valid[k]), int'(m_valid[k]));
            check_eq($sformatf("canal[%0d]", k), int'(d_canal[k]), m_canal[k]);
            check_eq($sformatf("saida[%0d]", k), int'(d_saida[k]), m_saida[k]);
        end
        @(negedge clk);
    endtask

    task automatic set_all(input logic [7:0] r, input logic [2:0] kk, input bit p);
        for (int k = 0; k < 4; k++) begin
            t_req[k]    = r & 8'((1 << cfg_n[k]) - 1);
            t_key[k]    = kk;
            t_pronta[k] = p;
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 1'b0;
            m_saida[k] = 0;
            m_canal[k] = 0;
            m_ptr[k]   = 0;
            for (int i = 0; i < 8; i++) t_ent[k][i] = 5'(i + 10);
        end
        rst = 1'b1;
        set_all(8'hFF, 3'd3, 1'b1);
        @(negedge clk);

        // Reset held with every channel requesting.
        step(1'b1);
        step(1'b1);

        // Fairness / wrap: full request sets with a ready consumer.
        t_req[1] = 8'b0001_0001;
        t_req[3] = 8'b0000_1000;
        repeat (10) step(1'b0);

        // Backpressure: three stalled cycles, then channel 1 withdraws.
        set_all(8'b0000_0110, 3'd3, 1'b1);
        t_req[1] = 8'b0001_0001;
        step(1'b0);
        for (int k = 0; k < 4; k++) t_pronta[k] = 1'b0;
        repeat (3) step(1'b0);
        for (int k = 0; k < 4; k++) t_pronta[k] = 1'b1;
        t_req[2] = 8'b0000_0100;
        repeat (2) step(1'b0);

        // Key mode: valid key, out-of-range key, key on an idle channel.
        set_all(8'b0000_1000, 3'd3, 1'b1);
        step(1'b0);
        for (int k = 0; k < 4; k++) t_key[k] = 3'd7;
        step(1'b0);
        for (int k = 0; k < 4; k++) t_key[k] = 3'd2;
        repeat (2) step(1'b0);

        // Reset while a stalled word is held.
        set_all(8'hFF, 3'd3, 1'b1);
        step(1'b0);
        for (int k = 0; k < 4; k++) t_pronta[k] = 1'b0;
        step(1'b0);
        step(1'b1);
        for (int k = 0; k < 4; k++) t_pronta[k] = 1'b1;
        repeat (2) step(1'b0);

        // Randomised traffic with occasional resets.
        repeat (400) begin
            for (int k = 0; k < 4; k++) begin
                t_req[k] = 8'($urandom) & 8'((1 << cfg_n[k]) - 1);
                if ($urandom_range(0, 3) == 0) t_req[k] = '0;
                t_key[k]    = 3'($urandom_range(0, 7));
                t_pronta[k] = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 8; i++) t_ent[k][i] = 5'($urandom);
            end
            step($urandom_range(0, 60) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
